// File: rtl/sync_ram_pkg.sv
// -----------------------------------------------------------------------------
// sync_ram_pkg
// Shared definitions for the sync_ram_dp slice:
//   RDW_READ_FIRST / RDW_WRITE_FIRST - same-address read-during-write policies
//   init_state_e                     - clear-sequencer states {INIT, READY}
//   byte_parity()                    - even-parity bit for one byte
// -----------------------------------------------------------------------------
package sync_ram_pkg;

    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;

    typedef enum logic [0:0] {
        INIT  = 1'b0,
        READY = 1'b1
    } init_state_e;

    // Even parity: the stored bit makes the 9-bit group hold an even count of ones.
    function automatic logic byte_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/sync_ram_init_seq.sv
// -----------------------------------------------------------------------------
// sync_ram_init_seq
// Memory clear sequencer. After reset it sweeps addresses 0..DEPTH-1, one per
// clock, ascending, then parks in READY until the next reset.
// Ports:
//   clk       - clock, rising edge
//   rst_n     - asynchronous active-low reset (restarts the sweep at address 0)
//   init_busy - high while the sweep runs (and while in reset)
//   clr_addr  - address being cleared this cycle
//   clr_we    - clear write strobe, qualifies clr_addr
// -----------------------------------------------------------------------------
module sync_ram_init_seq
    import sync_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  init_busy,
    output logic [ADDR_WIDTH-1:0] clr_addr,
    output logic                  clr_we
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ONE_ADDR  = ADDR_WIDTH'(1'b1);

    init_state_e           state_r;
    init_state_e           state_nxt_s;
    logic [ADDR_WIDTH-1:0] cnt_r;
    logic [ADDR_WIDTH-1:0] cnt_nxt_s;

    // State and sweep-counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= INIT;
            cnt_r   <= ZERO_ADDR;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Next-state logic: leave INIT on the cycle that clears the last address
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            INIT: begin
                if (cnt_r == LAST_ADDR) begin
                    state_nxt_s = READY;
                    cnt_nxt_s   = ZERO_ADDR;
                end else begin
                    state_nxt_s = INIT;
                    cnt_nxt_s   = cnt_r + ONE_ADDR;
                end
            end
            READY: begin
                state_nxt_s = READY;
                cnt_nxt_s   = ZERO_ADDR;
            end
            default: begin
                state_nxt_s = INIT;
                cnt_nxt_s   = ZERO_ADDR;
            end
        endcase
    end

    assign init_busy = (state_r == INIT);
    assign clr_we    = (state_r == INIT);
    assign clr_addr  = cnt_r;

endmodule

// File: rtl/sync_ram_dp.sv
// -----------------------------------------------------------------------------
// sync_ram_dp
// Simple dual-port synchronous RAM (one write port, one read port, one clock)
// with byte enables, a post-reset clear sweep, a 1- or 2-stage pipelined read
// path and a selectable same-address read-during-write policy.
// Optional build macro SYNC_RAM_PARITY_EN adds one even-parity bit per byte,
// the error-injection input inj_perr and the read error flag rd_perr.
// Ports:
//   clk, rst_n         - clock (rising edge) and asynchronous active-low reset
//   we, waddr, wdata   - write request, address, data
//   wbe                - byte enables, bit i covers wdata[8i+7:8i]
//   re, raddr          - read request and address
//   rdata, rvalid      - read data (held between reads) and one-cycle qualifier
//   init_busy          - high while the clear sweep runs
//   inj_perr, rd_perr  - parity build only: invert stored parity / parity error
// Memory contents are not reset; only the clear sweep zeroes them.
// -----------------------------------------------------------------------------
module sync_ram_dp
    import sync_ram_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6,
    parameter int RD_LATENCY = 1,
    parameter int RDW_MODE   = RDW_READ_FIRST
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    we,
    input  logic [ADDR_WIDTH-1:0]   waddr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wbe,
    input  logic                    re,
    input  logic [ADDR_WIDTH-1:0]   raddr,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    rvalid,
`ifdef SYNC_RAM_PARITY_EN
    input  logic                    inj_perr,
    output logic                    rd_perr,
`endif
    output logic                    init_busy
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic                  init_busy_s;
    logic                  clr_we_s;
    logic [ADDR_WIDTH-1:0] clr_addr_s;
    logic                  ready_s;

    sync_ram_init_seq #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_init_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .init_busy (init_busy_s),
        .clr_addr  (clr_addr_s),
        .clr_we    (clr_we_s)
    );

    assign ready_s   = ~init_busy_s;
    assign init_busy = init_busy_s;

    // ---------------- write port ----------------
    logic [NB-1:0]         wr_be_s;
    logic [ADDR_WIDTH-1:0] wr_addr_s;
    logic [DATA_WIDTH-1:0] wr_word_s;
    logic [DATA_WIDTH-1:0] rd_old_s;

    // Write arbitration: the clear sweep owns the array until READY, user writes are dropped
    always_comb begin
        wr_be_s   = {NB{1'b0}};
        wr_addr_s = waddr;
        wr_word_s = wdata;
        if (clr_we_s) begin
            wr_be_s   = {NB{1'b1}};
            wr_addr_s = clr_addr_s;
            wr_word_s = {DATA_WIDTH{1'b0}};
        end else if (we) begin
            wr_be_s   = wbe;
        end else begin
            wr_be_s   = {NB{1'b0}};
        end
    end

`ifdef SYNC_RAM_PARITY_EN
    logic [NB-1:0] wr_par_s;
    logic [NB-1:0] rd_old_par_s;

    // Parity to store per byte; injection only applies to user writes, never to the sweep
    always_comb begin
        wr_par_s = {NB{1'b0}};
        for (int i = 0; i < NB; i++) begin
            wr_par_s[i] = byte_parity(wr_word_s[8*i +: 8]) ^ (inj_perr & ~clr_we_s);
        end
    end
`endif

    // One storage array per byte lane so each lane has a single writer
    for (genvar g = 0; g < NB; g++) begin : g_lane
        logic [7:0] lane_r [DEPTH];

        // Byte-lane storage write
        always_ff @(posedge clk) begin
            if (wr_be_s[g]) begin
                lane_r[wr_addr_s] <= wr_word_s[8*g +: 8];
            end
        end

        assign rd_old_s[8*g +: 8] = lane_r[raddr];

`ifdef SYNC_RAM_PARITY_EN
        logic lane_par_r [DEPTH];

        // Byte-lane parity storage write
        always_ff @(posedge clk) begin
            if (wr_be_s[g]) begin
                lane_par_r[wr_addr_s] <= wr_par_s[g];
            end
        end

        assign rd_old_par_s[g] = lane_par_r[raddr];
`endif
    end

    // ---------------- read port ----------------
    logic                  rd_fire_s;
    logic                  same_addr_wr_s;
    logic [DATA_WIDTH-1:0] rd_word_s;

    assign rd_fire_s      = ready_s & re;
    assign same_addr_wr_s = (RDW_MODE == RDW_WRITE_FIRST) && ready_s && we && (waddr == raddr);

    // Read word: array contents, or in write-first mode the byte-merged incoming write
    always_comb begin
        rd_word_s = rd_old_s;
        if (same_addr_wr_s) begin
            for (int i = 0; i < NB; i++) begin
                if (wbe[i]) begin
                    rd_word_s[8*i +: 8] = wdata[8*i +: 8];
                end else begin
                    rd_word_s[8*i +: 8] = rd_old_s[8*i +: 8];
                end
            end
        end else begin
            rd_word_s = rd_old_s;
        end
    end

`ifdef SYNC_RAM_PARITY_EN
    logic [NB-1:0] rd_par_s;
    logic          rd_perr_s;

    // Stored parity for the returned word (merged like the data) and the recomputed check
    always_comb begin
        rd_par_s  = rd_old_par_s;
        rd_perr_s = 1'b0;
        for (int i = 0; i < NB; i++) begin
            if (same_addr_wr_s && wbe[i]) begin
                rd_par_s[i] = wr_par_s[i];
            end else begin
                rd_par_s[i] = rd_old_par_s[i];
            end
            rd_perr_s = rd_perr_s | (byte_parity(rd_word_s[8*i +: 8]) ^ rd_par_s[i]);
        end
    end
`endif

    logic                  out_fire_s;
    logic [DATA_WIDTH-1:0] out_data_s;
`ifdef SYNC_RAM_PARITY_EN
    logic                  out_perr_s;
`endif

    if (RD_LATENCY == 2) begin : g_lat2
        logic                  s1_valid_r;
        logic [DATA_WIDTH-1:0] s1_data_r;
`ifdef SYNC_RAM_PARITY_EN
        logic                  s1_perr_r;
`endif

        // Extra read stage; cleared by reset so no in-flight read survives it
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1_valid_r <= 1'b0;
                s1_data_r  <= {DATA_WIDTH{1'b0}};
`ifdef SYNC_RAM_PARITY_EN
                s1_perr_r  <= 1'b0;
`endif
            end else begin
                s1_valid_r <= rd_fire_s;
                if (rd_fire_s) begin
                    s1_data_r <= rd_word_s;
`ifdef SYNC_RAM_PARITY_EN
                    s1_perr_r <= rd_perr_s;
`endif
                end
            end
        end

        assign out_fire_s = s1_valid_r;
        assign out_data_s = s1_data_r;
`ifdef SYNC_RAM_PARITY_EN
        assign out_perr_s = s1_perr_r;
`endif
    end else begin : g_lat1
        assign out_fire_s = rd_fire_s;
        assign out_data_s = rd_word_s;
`ifdef SYNC_RAM_PARITY_EN
        assign out_perr_s = rd_perr_s;
`endif
    end

    // Output register: rdata holds between reads, rvalid is a one-cycle pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata  <= {DATA_WIDTH{1'b0}};
            rvalid <= 1'b0;
        end else begin
            rvalid <= out_fire_s;
            if (out_fire_s) begin
                rdata <= out_data_s;
            end
        end
    end

`ifdef SYNC_RAM_PARITY_EN
    // Parity error flag, only ever high alongside rvalid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_perr <= 1'b0;
        end else begin
            rd_perr <= out_fire_s & out_perr_s;
        end
    end
`endif

endmodule
